// File: rtl/exec_stage.sv
// Two-slot execute stage: EX slot drives the ALU, RES slot holds its result.
// Forwards from both slots into issuing operands and resolves branch-on-zero.
`timescale 1ns/1ps
module exec_stage #(
  parameter int WORD_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_op,
  input  logic [WORD_SIZE-1:0] in_a,
  input  logic [WORD_SIZE-1:0] in_b,
  input  logic [WORD_SIZE-1:0] in_imm,
  input  logic                 in_use_imm,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [4:0]           in_rd,
  input  logic                 in_wb_en,
  input  logic                 in_branch,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic [3:0]           alu_op,
  input  logic [WORD_SIZE-1:0] alu_out,
  input  logic                 alu_zero,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_result,
  output logic [4:0]           out_rd,
  output logic                 out_wb_en,
  output logic                 out_taken,
  output logic                 out_illegal
);

  typedef struct packed {
    logic [3:0]           op;
    logic [WORD_SIZE-1:0] a;
    logic [WORD_SIZE-1:0] b;
    logic [4:0]           rd;
    logic                 wb;
    logic                 br;
    logic                 ill;
  } ex_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0] res;
    logic [4:0]           rd;
    logic                 wb;
    logic                 taken;
    logic                 ill;
  } res_t;

  logic ex_valid_q, ex_valid_d;
  logic res_valid_q, res_valid_d;
  ex_t  ex_q, ex_d;
  res_t res_q, res_d;

  logic res_free, ex_adv, accept;
  logic ex_fwd_ok, res_fwd_ok;
  logic [WORD_SIZE-1:0] opa, opb;

  assign res_free = !res_valid_q || out_ready;
  assign ex_adv   = ex_valid_q && res_free;
  assign in_ready = !ex_valid_q || ex_adv;
  assign accept   = in_valid && in_ready;

  // Illegal producers carry wb=0 in RES, so only EX needs the explicit guard
  assign ex_fwd_ok  = ex_valid_q && ex_q.wb && !ex_q.ill;
  assign res_fwd_ok = res_valid_q && res_q.wb;

  always_comb begin
    opa = in_a;
    if (in_rs1 != 5'd0 && ex_fwd_ok && ex_q.rd == in_rs1) begin
      opa = alu_out;
    end else if (in_rs1 != 5'd0 && res_fwd_ok && res_q.rd == in_rs1) begin
      opa = res_q.res;
    end
  end

  always_comb begin
    opb = in_b;
    if (in_use_imm) begin
      opb = in_imm;
    end else if (in_rs2 != 5'd0 && ex_fwd_ok && ex_q.rd == in_rs2) begin
      opb = alu_out;
    end else if (in_rs2 != 5'd0 && res_fwd_ok && res_q.rd == in_rs2) begin
      opb = res_q.res;
    end
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (accept) begin
      ex_valid_d = 1'b1;
      ex_d.op    = in_op;
      ex_d.a     = opa;
      ex_d.b     = opb;
      ex_d.rd    = in_rd;
      ex_d.wb    = in_wb_en;
      ex_d.br    = in_branch;
      ex_d.ill   = (in_op > 4'd10);
    end else if (ex_adv) begin
      ex_valid_d = 1'b0;
    end
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_d       = res_q;
    if (ex_adv) begin
      res_valid_d = 1'b1;
      res_d.res   = ex_q.ill ? '0 : alu_out;
      res_d.rd    = ex_q.rd;
      res_d.wb    = ex_q.wb && !ex_q.ill;
      res_d.taken = ex_q.br && alu_zero && !ex_q.ill;
      res_d.ill   = ex_q.ill;
    end else if (out_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      res_valid_q <= 1'b0;
      ex_q        <= '0;
      res_q       <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      res_valid_q <= res_valid_d;
      ex_q        <= ex_d;
      res_q       <= res_d;
    end
  end

  assign alu_a  = ex_q.a;
  assign alu_b  = ex_q.b;
  assign alu_op = ex_q.ill ? 4'd0 : ex_q.op;

  assign out_valid   = res_valid_q;
  assign out_result  = res_q.res;
  assign out_rd      = res_q.rd;
  assign out_wb_en   = res_q.wb;
  assign out_taken   = res_q.taken;
  assign out_illegal = res_q.ill;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage with a behavioural ALU and a result scoreboard.
`timescale 1ns/1ps
module tb_exec_stage;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, in_use_imm, in_wb_en, in_branch;
  logic [3:0] in_op, alu_op;
  logic [W-1:0] in_a, in_b, in_imm, alu_a, alu_b, alu_out, out_result;
  logic [4:0] in_rs1, in_rs2, in_rd, out_rd;
  logic alu_zero, out_valid, out_ready, out_wb_en, out_taken, out_illegal;

  always #5 clk = ~clk;

  exec_stage #(.WORD_SIZE(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_wb_en(in_wb_en), .in_branch(in_branch),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wb_en(out_wb_en),
    .out_taken(out_taken), .out_illegal(out_illegal)
  );

  always_comb begin
    alu_out = '0;
    case (alu_op)
      4'd0:  alu_out = alu_a + alu_b;
      4'd1:  alu_out = alu_a - alu_b;
      4'd2:  alu_out = alu_a & alu_b;
      4'd3:  alu_out = alu_a | alu_b;
      4'd4:  alu_out = W'(alu_a == alu_b);
      4'd5:  alu_out = alu_a ^ alu_b;
      4'd6:  alu_out = W'(alu_a < alu_b);
      4'd7:  alu_out = W'(alu_a <= alu_b);
      4'd8:  alu_out = W'(alu_a > alu_b);
      4'd9:  alu_out = W'(alu_a >= alu_b);
      4'd10: alu_out = ~alu_a;
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   rd;
    logic         wb;
    logic         taken;
    logic         ill;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      assert (sb.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_output: observed result %0h, expected none",
               out_result);
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("out_result", out_result, e.res);
        chk("out_rd", W'(out_rd), W'(e.rd));
        chk("out_wb_en", W'(out_wb_en), W'(e.wb));
        chk("out_taken", W'(out_taken), W'(e.taken));
        chk("out_illegal", W'(out_illegal), W'(e.ill));
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] imm,
                       input logic use_imm, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic wb, input logic br);
    in_op = op; in_a = a; in_b = b; in_imm = imm;
    in_use_imm = use_imm; in_rs1 = rs1; in_rs2 = rs2;
    in_rd = rd; in_wb_en = wb; in_branch = br;
    in_valid = 1'b1;
  endtask

  // Returns at posedge+1 of the accepting edge; in_valid is left high
  task automatic send(input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] imm,
                      input logic use_imm, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd,
                      input logic wb, input logic br,
                      input logic [W-1:0] eres, input logic etaken);
    logic ok;
    logic ill;
    exp_t e;
    drive(op, a, b, imm, use_imm, rs1, rs2, rd, wb, br);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    chk("accept_timeout", W'(ok), W'(1));
    if (ok) begin
      ill = (op > 4'd10);
      e.res = eres; e.rd = rd; e.wb = wb && !ill;
      e.taken = etaken; e.ill = ill;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic single_add(input string tag);
    send(4'd0, 5, 7, 0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 12, 1'b0);
    in_valid = 1'b0;
    chk({tag, "_alu_a"}, alu_a, 5);
    chk({tag, "_alu_b"}, alu_b, 7);
    chk({tag, "_valid_early"}, W'(out_valid), W'(0));
    @(posedge clk);
    #1;
    chk({tag, "_valid_lat2"}, W'(out_valid), W'(1));
    chk({tag, "_result"}, out_result, 12);
    idle(2);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_imm = '0;
    in_use_imm = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_wb_en = 1'b0; in_branch = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", W'(alu_op), W'(0));
    chk("rst_out_result", out_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    single_add("add");

    // EX forwarding: dependent op issued back-to-back
    send(4'd1, 10, 4, 0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 6, 1'b0);
    send(4'd0, 0, 0, 1, 1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 7, 1'b0);
    chk("fwd_ex_alu_a", alu_a, 6);
    idle(3);

    // RES forwarding: one bubble between producer and consumer
    send(4'd1, 10, 4, 0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 6, 1'b0);
    idle(1);
    send(4'd0, 0, 0, 1, 1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 7, 1'b0);
    chk("fwd_res_alu_a", alu_a, 6);
    idle(3);

    // Backpressure: two ops fit, the third waits
    out_ready = 1'b0;
    send(4'd0, 1, 1, 0, 1'b0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 2, 1'b0);
    send(4'd0, 2, 2, 0, 1'b0, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 4, 1'b0);
    drive(4'd0, 3, 3, 0, 1'b0, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", W'(in_ready), W'(0));
      chk("bp_out_valid", W'(out_valid), W'(1));
      chk("bp_out_stable", out_result, 2);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(4'd0, 3, 3, 0, 1'b0, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 6, 1'b0);
    idle(3);

    // Branch resolution
    send(4'd4, 9, 9, 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1, 1'b0);
    send(4'd1, 9, 9, 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 0, 1'b1);
    idle(3);

    // Illegal opcode and no forwarding from it
    send(4'd13, 3, 4, 0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 0, 1'b0);
    chk("ill_alu_op", W'(alu_op), W'(0));
    send(4'd0, 3, 4, 0, 1'b0, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 7, 1'b0);
    chk("ill_nofwd_alu_a", alu_a, 3);
    idle(3);

    // Asynchronous reset with both slots full
    out_ready = 1'b0;
    send(4'd0, 20, 1, 0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 21, 1'b0);
    send(4'd0, 30, 1, 0, 1'b0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 31, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", W'(out_valid), W'(0));
    chk("mrst_in_ready", W'(in_ready), W'(1));
    chk("mrst_alu_a", alu_a, 0);
    chk("mrst_out_result", out_result, 0);
    sb.delete();
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    single_add("post_rst");

    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", W'(sb.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
# exec_stage

Two-slot execute pipeline stage that sits directly upstream of the ALU and consumes its result. It accepts decoded operations over a valid/ready handshake and holds them in an EX slot that drives the ALU combinationally. The ALU output is captured into a RES slot that feeds the memory/writeback stage. The stage selects operand B from the register or immediate path, forwards results from its own two slots into newly issued operands, rejects illegal opcodes, and resolves branch-on-zero.

## Interface
- WORD_SIZE, 64, datapath width; must match the ALU instance.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid / in_ready  in / out  1  upstream handshake; transfer when both are high at a rising edge.
- in_op  in  4  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 EQ, 5 XOR, 6 LT, 7 LE, 8 GT, 9 GE, 10 NOT.
- in_a, in_b, in_imm  in  WORD_SIZE  register operands and immediate.
- in_use_imm  in  1  selects in_imm as operand B.
- in_rs1, in_rs2, in_rd  in  5  source and destination register indices.
- in_wb_en, in_branch  in  1  write-back request; branch-if-ALU-zero request.
- alu_a, alu_b  out  WORD_SIZE  driven from the EX slot.
- alu_op  out  4  driven from the EX slot.
- alu_out  in  WORD_SIZE  ALU result.
- alu_zero  in  1  ALU zero flag.
- out_valid / out_ready  out / in  1  downstream handshake.
- out_result  out  WORD_SIZE  captured ALU result.
- out_rd  out  5  destination register index.
- out_wb_en  out  1  write-back enable.
- out_taken  out  1  branch resolved as taken.
- out_illegal  out  1  illegal opcode flag.

## Operation
- Each slot (EX, RES) has its own valid bit and payload.
- RES advance: `res_free = !res_valid || out_ready`.
- EX advance: `ex_adv = ex_valid && res_free`.
- `in_ready = !ex_valid || ex_adv`. This is combinational, so back-to-back issue is possible at full throughput.
- Accept: EX captures op, operands (after forwarding and immediate selection), rd, wb_en, and branch. Otherwise, EX clears its valid bit on ex_adv, or holds.
- Immediate select: if in_use_imm is set, operand B is in_imm and forwarding on rs2 is suppressed.
- Forwarding, applied per source with index rs:
  - Sources match only when rs != 0 and the producer has wb_en set.
  - First priority: EX valid and EX rd == rs; use alu_out.
  - Second priority: RES valid and out_rd == rs; use out_result.
  - Otherwise use the raw input.
- Illegal opcode (11–15):
  - Drive alu_op = ADD while the operation is in EX.
  - In RES: out_result = 0, out_illegal = 1, out_wb_en = 0, out_taken = 0.
  - An illegal producer never matches for forwarding.
- RES capture on ex_adv:
  - out_result = alu_out.
  - out_taken = EX branch && alu_zero.
  - Comparison results are 1 or 0, zero-extended to WORD_SIZE.
  - Arithmetic wraps modulo 2^WORD_SIZE.
- Clear: on out_ready with no ex_adv, RES valid clears.
- Stall: while out_valid && !out_ready, RES holds and all out_* signals stay stable.
- Reset: all valid bits and all outputs are 0, including alu_a, alu_b, and alu_op. A reset mid-operation discards both slots, with no partial outputs.

## Timing
- Latency: accept at edge N; alu_* signals valid during cycle N+1; out_valid high from edge N+1 (after the ALU settles) through the edge at which it is consumed. Result appears two edges after acceptance when there is no stall.
- Throughput is one operation per cycle when out_ready is held high.
- With RES full and out_ready low, EX can still accept one more operation. After that, in_ready drops in the same cycle.
- Simultaneous out_ready and a full EX: RES is replaced and EX refilled in the same edge, with no bubble.
- alu_out and alu_zero are sampled only at edges where ex_adv is high.

## Test plan
- Single ADD, a=5, b=7, out_ready=1: out_valid appears 2 edges after accept with out_result=12, out_wb_en=1, out_taken=0.
- Back-to-back dependent ops, SUB r3=10-4, then ADD r4=r3+1 with rs1=3 and stale in_a=0: second result is 7 (EX forwarding). Insert one bubble and the result is still 7 (RES forwarding).
- Backpressure with out_ready=0 for 5 cycles while streaming 3 ops: exactly 2 are accepted, in_ready goes low, out_result stays stable. On release, results arrive in order with none lost or duplicated.
- Branch with EQ a=b=9: alu_out=1, zero=0, out_taken=0. Branch with SUB a=b=9: out_taken=1, out_result=0.
- Opcode 13 with wb_en=1: out_illegal=1, out_result=0, out_wb_en=0. A following op with rs1 equal to its rd is not forwarded.
- rst_n pulsed low while both slots are valid: out_valid=0 and in_ready=1 immediately (asynchronously). The first op after release behaves as in the single-ADD case.
